db_sao_cost_sched: RTL and testbench

DB_SAO_COST_SCHED -- requirements
Module: db_sao_cost_sched

---
 rtl/db_sao_pkg.sv | 29 ++
 rtl/db_sao_compare_cost.sv | 36 +++
 rtl/db_sao_cost_sched.sv | 121 ++++++++++++
 tb/tb_db_sao_cost_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_sao_pkg.sv
// Shared definitions for the SAO cost scheduler: FSM states, SAO type codes
// and the derivation of the signed cost width from the distortion width.
package db_sao_pkg;

    // Scheduler states, 2-bit binary encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CMP  = 2'd2,
        ST_OUT  = 2'd3
    } sao_state_e;

    // SAO type codes reported on res_type_o.
    localparam logic [2:0] SAO_OFF = 3'd0;
    localparam logic [2:0] SAO_EO0 = 3'd1;
    localparam logic [2:0] SAO_EO1 = 3'd2;
    localparam logic [2:0] SAO_EO2 = 3'd3;
    localparam logic [2:0] SAO_EO3 = 3'd4;
    localparam logic [2:0] SAO_BO  = 3'd5;

    // Candidates per component: EO0..EO3 then BO.
    localparam int NUM_CAND = 5;

    // Signed cost width: distortion plus three bits of headroom.
    function automatic int cost_width(input int dis_width);
        return dis_width + 3;
    endfunction

endpackage

// File: rtl/db_sao_compare_cost.sv
// Combinational 5-input signed minimum; on equal costs the lowest index wins.
module db_sao_compare_cost #(
    parameter int CW = 28
) (
    input  logic signed [CW-1:0] cost0,
    input  logic signed [CW-1:0] cost1,
    input  logic signed [CW-1:0] cost2,
    input  logic signed [CW-1:0] cost3,
    input  logic signed [CW-1:0] cost4,
    output logic        [2:0]    min_idx,
    output logic signed [CW-1:0] min_cost
);

    // Linear scan with strict less-than so an equal later cost never displaces an earlier one.
    always_comb begin
        min_idx  = 3'd0;
        min_cost = cost0;
        if (cost1 < min_cost) begin
            min_idx  = 3'd1;
            min_cost = cost1;
        end
        if (cost2 < min_cost) begin
            min_idx  = 3'd2;
            min_cost = cost2;
        end
        if (cost3 < min_cost) begin
            min_idx  = 3'd3;
            min_cost = cost3;
        end
        if (cost4 < min_cost) begin
            min_idx  = 3'd4;
            min_cost = cost4;
        end
    end

endmodule

// File: rtl/db_sao_cost_sched.sv
// SAO cost scheduler: per CTB, loads five candidate costs for each of Y, U, V,
// picks the cheapest (off when no candidate is negative), emits one result per
// component and accumulates the CTB total.
//
// Handshakes: a cost moves when cost_valid_i && cost_ready_o at a rising edge;
// a result moves when res_valid_o && res_ready_i at a rising edge. The producer
// side never needs to wait on ready before raising valid, and result outputs
// hold steady while res_valid_o is high and res_ready_i is low.
module db_sao_cost_sched
    import db_sao_pkg::*;
#(
    parameter int  DIS_WIDTH = 25,
    parameter int  CMP_NUM   = 3,
    localparam int CW        = cost_width(DIS_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic signed [CW-1:0] cost_i,
    input  logic                 cost_valid_i,
    output logic                 cost_ready_o,
    output logic        [2:0]    res_type_o,
    output logic signed [CW-1:0] res_cost_o,
    output logic        [1:0]    res_cmp_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic signed [CW+1:0] ctb_cost_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [2:0] LAST_CAND = 3'(NUM_CAND - 1);
    localparam logic [1:0] LAST_CMP  = 2'(CMP_NUM - 1);

    sao_state_e           state;
    logic        [2:0]    cand_cnt;
    logic signed [CW-1:0] slot [NUM_CAND];
    logic        [2:0]    min_idx;
    logic signed [CW-1:0] min_cost;

    db_sao_compare_cost #(
        .CW (CW)
    ) u_cmp (
        .cost0    (slot[0]),
        .cost1    (slot[1]),
        .cost2    (slot[2]),
        .cost3    (slot[3]),
        .cost4    (slot[4]),
        .min_idx  (min_idx),
        .min_cost (min_cost)
    );

    // Handshake readiness and activity are straight decodes of the state register.
    assign cost_ready_o = (state == ST_LOAD);
    assign res_valid_o  = (state == ST_OUT);
    assign busy_o       = (state != ST_IDLE) || done_o;

    // Scheduler FSM: load five costs, register the minimum, present the result, repeat per component.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cand_cnt   <= 3'd0;
            res_cmp_o  <= 2'd0;
            res_type_o <= SAO_OFF;
            res_cost_o <= '0;
            ctb_cost_o <= '0;
            done_o     <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                slot[i] <= '0;
            end
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        res_cmp_o  <= 2'd0;
                        cand_cnt   <= 3'd0;
                        ctb_cost_o <= '0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cost_valid_i) begin
                        slot[cand_cnt] <= cost_i;
                        if (cand_cnt == LAST_CAND) begin
                            state <= ST_CMP;
                        end else begin
                            cand_cnt <= cand_cnt + 3'd1;
                        end
                    end
                end
                ST_CMP: begin
                    // Only a strictly negative cost beats leaving SAO off.
                    if (min_cost < 0) begin
                        res_type_o <= min_idx + 3'd1;
                        res_cost_o <= min_cost;
                    end else begin
                        res_type_o <= SAO_OFF;
                        res_cost_o <= '0;
                    end
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready_i) begin
                        // Two guard bits make the three-component sum wrap-free.
                        ctb_cost_o <= ctb_cost_o + {{2{res_cost_o[CW-1]}}, res_cost_o};
                        if (res_cmp_o == LAST_CMP) begin
                            done_o <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            res_cmp_o <= res_cmp_o + 2'd1;
                            cand_cnt  <= 3'd0;
                            state     <= ST_LOAD;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_db_sao_cost_sched.sv
// Self-checking bench for db_sao_cost_sched: directed CTB runs, a scoreboard
// fed by a behavioural pick-the-cheapest model, and literal result checks.
module tb_db_sao_cost_sched;

    localparam int CW = 28;
    localparam int W  = CW + 5;  // {type[2:0], cmp[1:0], cost[CW-1:0]}

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_i;
    logic signed [CW-1:0] cost_i;
    logic                 cost_valid_i;
    logic                 cost_ready_o;
    logic        [2:0]    res_type_o;
    logic signed [CW-1:0] res_cost_o;
    logic        [1:0]    res_cmp_o;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic signed [CW+1:0] ctb_cost_o;
    logic                 busy_o;
    logic                 done_o;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    longint       exp_ctb = 0;

    logic                 prev_valid = 1'b0;
    logic                 prev_ready = 1'b0;
    logic [2:0]           prev_type;
    logic signed [CW-1:0] prev_cost;
    logic [1:0]           prev_cmp;
    logic signed [CW+1:0] prev_ctb;

    db_sao_cost_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .cost_i       (cost_i),
        .cost_valid_i (cost_valid_i),
        .cost_ready_o (cost_ready_o),
        .res_type_o   (res_type_o),
        .res_cost_o   (res_cost_o),
        .res_cmp_o    (res_cmp_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .ctb_cost_o   (ctb_cost_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: cheapest candidate, lowest index on ties, off unless strictly negative.
    function automatic logic [W-1:0] model_pick(input int cmp, input logic signed [CW-1:0] c [5]);
        int best = 0;
        for (int i = 1; i < 5; i++) begin
            if (c[i] < c[best]) best = i;
        end
        if (c[best] < 0) return {3'(best + 1), 2'(cmp), c[best]};
        return {3'd0, 2'(cmp), {CW{1'b0}}};
    endfunction

    // Scoreboard: checks every result handshake, stalls, and CTB total at done.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        logic signed [CW-1:0] ec;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (start_i && !busy_o) begin
                exp_ctb = 0;
                got_q.delete();
            end
            if (res_valid_o) begin
                chk("ready_low_in_out", longint'(cost_ready_o), 0);
                if (prev_valid && !prev_ready) begin
                    chk("stall_type", longint'(res_type_o), longint'(prev_type));
                    chk("stall_cost", longint'(res_cost_o), longint'(prev_cost));
                    chk("stall_cmp", longint'(res_cmp_o), longint'(prev_cmp));
                    chk("stall_ctb", longint'(ctb_cost_o), longint'(prev_ctb));
                end
                if (res_ready_i) begin
                    a = {res_type_o, res_cmp_o, res_cost_o};
                    got_q.push_back(a);
                    cmp_cnt++;
                    if (exp_q.size() == 0) begin
                        err_cnt++;
                        $display("FAIL result_unexpected: got %h, expected none", a);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            err_cnt++;
                            $display("FAIL result: got %h, expected %h", a, e);
                        end
                        ec = e[CW-1:0];
                        exp_ctb = exp_ctb + longint'(ec);
                    end
                end
            end
            if (done_o) begin
                chk("ctb_at_done", longint'(ctb_cost_o), exp_ctb);
                chk("busy_at_done", longint'(busy_o), 1);
            end
            prev_valid = res_valid_o;
            prev_ready = res_ready_i;
            prev_type  = res_type_o;
            prev_cost  = res_cost_o;
            prev_cmp   = res_cmp_o;
            prev_ctb   = ctb_cost_o;
        end
    end

    // Driver: present one cost and hold it until accepted.
    task automatic send_cost(input logic signed [CW-1:0] c);
        bit r;
        bit ok = 1'b0;
        cost_valid_i = 1'b1;
        cost_i       = c;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            r = cost_ready_o;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("cost_accept_timeout", 0, 1);
        cost_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Driver: one full CTB with optional gaps, result stall and a stray start.
    task automatic run_ctb(input logic signed [CW-1:0] v [15], input bit gapped,
                           input int stall, input bit poke, input int exp_edges);
        logic signed [CW-1:0] c5 [5];
        int  start_cyc;
        bit  got_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 5; j++) c5[j] = v[k*5 + j];
            exp_q.push_back(model_pick(k, c5));
        end
        res_ready_i = (stall == 0);
        pulse_start();
        start_cyc = cyc;
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    if (gapped && i > 0) begin
                        cost_valid_i = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_cost(v[i]);
                end
            end
            begin
                if (stall > 0 || poke) begin
                    bit seen = 1'b0;
                    for (int n = 0; n < 100; n++) begin
                        @(negedge clk);
                        if (res_valid_o) begin
                            seen = 1'b1;
                            break;
                        end
                    end
                    if (!seen) chk("res_valid_timeout", 0, 1);
                    if (poke) begin
                        start_i = 1'b1;
                        @(posedge clk);
                        #1;
                        start_i = 1'b0;
                    end
                    if (stall > 0) begin
                        repeat (stall) @(posedge clk);
                        #1;
                        res_ready_i = 1'b1;
                    end
                end
            end
        join
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        else if (exp_edges > 0) chk("done_cycle", longint'(cyc - start_cyc + 1), longint'(exp_edges));
        repeat (3) @(negedge clk);
        chk("busy_after_done", longint'(busy_o), 0);
        chk("ctb_hold", longint'(ctb_cost_o), exp_ctb);
        chk("exp_q_drained", longint'(exp_q.size()), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input int idx, input int et, input longint ecost, input int ecmp);
        logic [W-1:0] g;
        logic signed [CW-1:0] gc;
        g  = got_q[idx];
        gc = g[CW-1:0];
        chk($sformatf("lit_type%0d", idx), longint'(g[W-1 -: 3]), longint'(et));
        chk($sformatf("lit_cost%0d", idx), longint'(gc), ecost);
        chk($sformatf("lit_cmp%0d", idx), longint'(g[CW +: 2]), longint'(ecmp));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, longint'(cost_ready_o), 0);
        chk({tag, "_valid"}, longint'(res_valid_o), 0);
        chk({tag, "_busy"}, longint'(busy_o), 0);
        chk({tag, "_done"}, longint'(done_o), 0);
        chk({tag, "_type"}, longint'(res_type_o), 0);
        chk({tag, "_cost"}, longint'(res_cost_o), 0);
        chk({tag, "_cmp"}, longint'(res_cmp_o), 0);
        chk({tag, "_ctb"}, longint'(ctb_cost_o), 0);
    endtask

    int d037 [15] = '{-10, -30, -5, 0, -30, 5, 6, 7, 8, 9, -1, -1, -1, -1, -2};
    logic signed [CW-1:0] v037 [15];
    logic signed [CW-1:0] vzero [15];
    logic signed [CW-1:0] vmin [15];

    // Main sequence.
    initial begin
        longint mn;
        mn = -(longint'(1) << (CW - 1));
        for (int i = 0; i < 15; i++) begin
            v037[i]  = CW'(d037[i]);
            vzero[i] = '0;
            vmin[i]  = {1'b1, {(CW-1){1'b0}}};
        end
        rst          = 1'b1;
        start_i      = 1'b0;
        cost_i       = '0;
        cost_valid_i = 1'b0;
        res_ready_i  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reference data, no gaps, no stalls.
        run_ctb(v037, 1'b0, 0, 1'b0, 22);
        chk("run1_count", longint'(got_q.size()), 3);
        chk_res(0, 2, -30, 0);
        chk_res(1, 0, 0, 1);
        chk_res(2, 5, -2, 2);
        chk("run1_ctb", longint'(ctb_cost_o), -32);

        // All-zero costs: SAO off everywhere.
        run_ctb(vzero, 1'b0, 0, 1'b0, 22);
        chk_res(0, 0, 0, 0);
        chk_res(2, 0, 0, 2);
        chk("zero_ctb", longint'(ctb_cost_o), 0);

        // Consumer stall on the first result.
        run_ctb(v037, 1'b0, 4, 1'b0, 0);
        chk_res(0, 2, -30, 0);
        chk("stall_ctb", longint'(ctb_cost_o), -32);

        // Gapped cost_valid_i.
        run_ctb(v037, 1'b1, 0, 1'b0, 0);
        chk_res(0, 2, -30, 0);
        chk_res(1, 0, 0, 1);
        chk_res(2, 5, -2, 2);
        chk("gap_ctb", longint'(ctb_cost_o), -32);

        // Reset after the third Y cost, then a clean rerun.
        pulse_start();
        send_cost(CW'(-100));
        send_cost(CW'(-200));
        send_cost(CW'(-300));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_ctb(v037, 1'b0, 0, 1'b0, 22);
        chk("rst_count", longint'(got_q.size()), 3);
        chk_res(0, 2, -30, 0);
        chk_res(1, 0, 0, 1);
        chk_res(2, 5, -2, 2);
        chk("rst_ctb", longint'(ctb_cost_o), -32);

        // Most negative costs with a stray start during the first result.
        run_ctb(vmin, 1'b0, 0, 1'b1, 22);
        chk("min_count", longint'(got_q.size()), 3);
        chk_res(0, 1, mn, 0);
        chk_res(1, 1, mn, 1);
        chk_res(2, 1, mn, 2);
        chk("min_ctb", longint'(ctb_cost_o), 3 * mn);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
